// File: rtl/shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
// Shared definitions for the parameterised shift register:
//   - mode_e       : operation select encoding driven on the 3-bit mode port
//   - is_shift_mode: true for the modes that move bits by a distance k
// -----------------------------------------------------------------------------
package shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROTR  = 3'b100,
        MODE_ROTL  = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    // Shift/rotate modes are the ones that consume amt and count events.
    function automatic logic is_shift_mode(input logic [2:0] m);
        logic r;
        case (m)
            MODE_SHR, MODE_SHL, MODE_ASR, MODE_ROTR, MODE_ROTL: r = 1'b1;
            default:                                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage : shift_reg_pkg

// File: rtl/barrel_shift_unit.sv
// -----------------------------------------------------------------------------
// barrel_shift_unit
// Combinational next-state data path for the shift register.
//   data      in  WIDTH  current register contents
//   mode      in  3      operation select (shift_reg_pkg::mode_e)
//   k         in  AMT_W  shift/rotate distance
//   fill      in  1      serial fill bit for SHR/SHL (ignored by ASR/rotates)
//   next_data out WIDTH  shifted/rotated result (== data when not a legal shift)
//   sr_bit    out 1      bit exiting at the LSB side: data[k-1]
//   sl_bit    out 1      bit exiting at the MSB side: data[WIDTH-k]
//   shift_ok  out 1      shift/rotate mode with 0 < k < WIDTH
// -----------------------------------------------------------------------------
module barrel_shift_unit
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] k,
    input  logic             fill,
    output logic [WIDTH-1:0] next_data,
    output logic             sr_bit,
    output logic             sl_bit,
    output logic             shift_ok
);

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic [31:0]      k_ext_s;
    logic             k_legal_s;
    logic [WIDTH-1:0] hi_mask_s;   // k ones at the MSB end
    logic [WIDTH-1:0] lo_mask_s;   // k ones at the LSB end

    // Decode the distance, build the fill masks and select the shifted result.
    always_comb begin
        k_ext_s   = 32'(k);
        k_legal_s = (k != {AMT_W{1'b0}}) && (k_ext_s < 32'(WIDTH));
        hi_mask_s = ~(ONES >> k);
        lo_mask_s = ~(ONES << k);
        shift_ok  = k_legal_s && is_shift_mode(mode);

        case (mode)
            MODE_SHR:  next_data = (data >> k) | ({WIDTH{fill}} & hi_mask_s);
            MODE_ASR:  next_data = (data >> k) | ({WIDTH{data[WIDTH-1]}} & hi_mask_s);
            MODE_SHL:  next_data = (data << k) | ({WIDTH{fill}} & lo_mask_s);
            MODE_ROTR: next_data = (data >> k) | (data << (32'(WIDTH) - k_ext_s));
            MODE_ROTL: next_data = (data << k) | (data >> (32'(WIDTH) - k_ext_s));
            default:   next_data = data;
        endcase

        if (!shift_ok) begin
            next_data = data;
        end else begin
            next_data = next_data;
        end

        // Exiting bits: the last bit to leave each end after k single steps.
        sr_bit = 1'b0;
        sl_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            sr_bit = (k_ext_s == 32'(i + 1))     ? data[i] : sr_bit;
            sl_bit = (k_ext_s == 32'(WIDTH - i)) ? data[i] : sl_bit;
        end
    end

endmodule : barrel_shift_unit

// File: rtl/param_shift_register.sv
// -----------------------------------------------------------------------------
// param_shift_register
// Parameterised universal shift register with serial outputs and a saturating
// shift-event counter.
//   clk       in  1      rising-edge clock
//   rst       in  1      synchronous active-high reset
//   en        in  1      operation enable (low holds everything)
//   mode      in  3      HOLD/SHR/SHL/LOAD/ROTR/ROTL/ASR/CLEAR
//   amt       in  AMT_W  shift/rotate distance
//   SRin      in  1      fill bit for SHR
//   SLin      in  1      fill bit for SHL
//   P_in      in  WIDTH  parallel load data
//   P_out     out WIDTH  register state
//   SRout     out 1      last bit exited at the LSB (SHR/ASR/ROTR)
//   SLout     out 1      last bit exited at the MSB (SHL/ROTL)
//   zero      out 1      P_out == 0 (combinational)
//   shift_cnt out CNT_W  saturating count of effective shift/rotate events
// -----------------------------------------------------------------------------
module param_shift_register
    import shift_reg_pkg::*;
#(
    parameter  int               WIDTH     = 8,
    parameter  logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter  int               CNT_W     = 8,
    localparam int               AMT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic             SRin,
    input  logic             SLin,
    input  logic [WIDTH-1:0] P_in,
    output logic [WIDTH-1:0] P_out,
    output logic             SRout,
    output logic             SLout,
    output logic             zero,
    output logic [CNT_W-1:0] shift_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] p_out_r;
    logic             sr_out_r;
    logic             sl_out_r;
    logic [CNT_W-1:0] shift_cnt_r;

    logic             fill_s;
    logic [WIDTH-1:0] next_data_s;
    logic             sr_bit_s;
    logic             sl_bit_s;
    logic             shift_ok_s;
    logic [CNT_W-1:0] cnt_inc_s;

    // SHL fills from the left-shift serial input, everything else from SRin.
    always_comb begin
        if (mode == MODE_SHL) begin
            fill_s = SLin;
        end else begin
            fill_s = SRin;
        end
        cnt_inc_s = (shift_cnt_r == CNT_MAX) ? shift_cnt_r : shift_cnt_r + CNT_W'(1);
    end

    barrel_shift_unit #(
        .WIDTH (WIDTH)
    ) u_barrel_shift_unit (
        .data      (p_out_r),
        .mode      (mode),
        .k         (amt),
        .fill      (fill_s),
        .next_data (next_data_s),
        .sr_bit    (sr_bit_s),
        .sl_bit    (sl_bit_s),
        .shift_ok  (shift_ok_s)
    );

    // Register state, serial outputs and event counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_out_r     <= RESET_VAL;
            sr_out_r    <= 1'b0;
            sl_out_r    <= 1'b0;
            shift_cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            case (mode)
                MODE_LOAD: begin
                    p_out_r     <= P_in;
                    shift_cnt_r <= {CNT_W{1'b0}};
                end
                MODE_CLEAR: begin
                    p_out_r     <= {WIDTH{1'b0}};
                    shift_cnt_r <= {CNT_W{1'b0}};
                end
                MODE_SHR, MODE_ASR, MODE_ROTR: begin
                    if (shift_ok_s) begin
                        p_out_r     <= next_data_s;
                        sr_out_r    <= sr_bit_s;
                        shift_cnt_r <= cnt_inc_s;
                    end else begin
                        p_out_r     <= p_out_r;
                    end
                end
                MODE_SHL, MODE_ROTL: begin
                    if (shift_ok_s) begin
                        p_out_r     <= next_data_s;
                        sl_out_r    <= sl_bit_s;
                        shift_cnt_r <= cnt_inc_s;
                    end else begin
                        p_out_r     <= p_out_r;
                    end
                end
                default: begin
                    p_out_r <= p_out_r;
                end
            endcase
        end else begin
            p_out_r <= p_out_r;
        end
    end

    assign P_out     = p_out_r;
    assign SRout     = sr_out_r;
    assign SLout     = sl_out_r;
    assign shift_cnt = shift_cnt_r;
    assign zero      = (p_out_r == {WIDTH{1'b0}});

endmodule : param_shift_register

// File: tb/tb_param_shift_register.sv
// -----------------------------------------------------------------------------
// tb_param_shift_register
// Self-checking bench for param_shift_register (WIDTH=8, CNT_W=4, RESET_VAL=0).
// A reference model moves bits one position at a time, k times, so the exit
// bit is simply the last bit that fell off the end.
// -----------------------------------------------------------------------------
module tb_param_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [2:0] amt;
    logic       SRin;
    logic       SLin;
    logic [7:0] P_in;
    logic [7:0] P_out;
    logic       SRout;
    logic       SLout;
    logic       zero;
    logic [3:0] shift_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m_p   = 8'h00;
    logic       m_sr  = 1'b0;
    logic       m_sl  = 1'b0;
    int         m_cnt = 0;

    param_shift_register #(
        .WIDTH     (8),
        .RESET_VAL (8'h00),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .amt       (amt),
        .SRin      (SRin),
        .SLin      (SLin),
        .P_in      (P_in),
        .P_out     (P_out),
        .SRout     (SRout),
        .SLout     (SLout),
        .zero      (zero),
        .shift_cnt (shift_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare all outputs.
    task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                       input logic [2:0] a, input logic sri, input logic sli,
                       input logic [7:0] pi);
        rst = r; en = e; mode = m; amt = a; SRin = sri; SLin = sli; P_in = pi;
        if (r) begin
            m_p = 8'h00; m_sr = 1'b0; m_sl = 1'b0; m_cnt = 0;
        end else if (e) begin
            if (m == 3'd3) begin
                m_p = pi; m_cnt = 0;
            end else if (m == 3'd7) begin
                m_p = 8'h00; m_cnt = 0;
            end else if (m != 3'd0 && a != 3'd0) begin
                for (int s = 0; s < int'(a); s++) begin
                    case (m)
                        3'd1: begin m_sr = m_p[0]; m_p = {sri,     m_p[7:1]}; end
                        3'd6: begin m_sr = m_p[0]; m_p = {m_p[7],  m_p[7:1]}; end
                        3'd4: begin m_sr = m_p[0]; m_p = {m_p[0],  m_p[7:1]}; end
                        3'd2: begin m_sl = m_p[7]; m_p = {m_p[6:0], sli};    end
                        3'd5: begin m_sl = m_p[7]; m_p = {m_p[6:0], m_p[7]}; end
                        default: ;
                    endcase
                end
                if (m_cnt < 15) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        check_eq("p_out", 64'(P_out), 64'(m_p));
        check_eq("srout", 64'(SRout), 64'(m_sr));
        check_eq("slout", 64'(SLout), 64'(m_sl));
        check_eq("zero",  64'(zero),  64'(m_p == 8'h00));
        check_eq("cnt",   64'(shift_cnt), 64'(m_cnt));
    endtask

    initial begin
        // reset with LOAD FF pending
        cyc(1'b1, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 8'hFF);
        cyc(1'b1, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 8'hFF);
        check_eq("rst_p",    64'(P_out), 64'h00);
        check_eq("rst_zero", 64'(zero), 64'h1);
        check_eq("rst_cnt",  64'(shift_cnt), 64'h0);

        // LOAD A5, SHR 3 fill 1, ASR 2
        cyc(1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 8'hA5);
        cyc(1'b0, 1'b1, 3'd1, 3'd3, 1'b1, 1'b0, 8'h00);
        check_eq("shr_p",   64'(P_out), 64'hF4);
        check_eq("shr_sr",  64'(SRout), 64'h1);
        check_eq("shr_cnt", 64'(shift_cnt), 64'h1);
        cyc(1'b0, 1'b1, 3'd6, 3'd2, 1'b0, 1'b1, 8'h00);
        check_eq("asr_p",   64'(P_out), 64'hFD);
        check_eq("asr_sr",  64'(SRout), 64'h0);
        check_eq("asr_cnt", 64'(shift_cnt), 64'h2);

        // rotates ignore serial inputs
        cyc(1'b0, 1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 8'h81);
        cyc(1'b0, 1'b1, 3'd5, 3'd1, 1'b0, 1'b1, 8'h00);
        check_eq("rotl_p",  64'(P_out), 64'h03);
        check_eq("rotl_sl", 64'(SLout), 64'h1);
        cyc(1'b0, 1'b1, 3'd4, 3'd4, 1'b1, 1'b0, 8'h00);
        check_eq("rotr_p",  64'(P_out), 64'h30);

        // counter saturation
        cyc(1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 8'h01);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 3'd2, 3'd1, 1'b0, 1'b0, 8'h00);
        check_eq("sat_cnt",  64'(shift_cnt), 64'hF);
        check_eq("sat_p",    64'(P_out), 64'h00);
        check_eq("sat_zero", 64'(zero), 64'h1);
        cyc(1'b0, 1'b1, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);
        check_eq("clr_cnt",  64'(shift_cnt), 64'h0);

        // en=0 holds everything; amt=0 is a hold
        cyc(1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 8'h5B);
        cyc(1'b0, 1'b1, 3'd1, 3'd2, 1'b1, 1'b0, 8'h00);
        for (int md = 0; md < 8; md++) begin
            cyc(1'b0, 1'b0, 3'(md), 3'd0, 1'b1, 1'b1, 8'hC3);
            cyc(1'b0, 1'b0, 3'(md), 3'd5, 1'b1, 1'b1, 8'hC3);
        end
        check_eq("en0_p",   64'(P_out), 64'hD6);
        check_eq("en0_cnt", 64'(shift_cnt), 64'h1);
        for (int md = 1; md < 7; md++) begin
            if (md != 3) cyc(1'b0, 1'b1, 3'(md), 3'd0, 1'b1, 1'b1, 8'h00);
        end
        check_eq("amt0_p",   64'(P_out), 64'hD6);
        check_eq("amt0_cnt", 64'(shift_cnt), 64'h1);

        // reset overrides a shift in the same cycle
        cyc(1'b1, 1'b1, 3'd2, 3'd2, 1'b1, 1'b1, 8'h00);
        check_eq("rst_ovr_p", 64'(P_out), 64'h00);
        cyc(1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 8'h3C);
        check_eq("load_3c", 64'(P_out), 64'h3C);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_param_shift_register
